// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver with first-word-fall-through output.
// Latency 1 cycle from rvld to m_valid; a full FIFO drops bytes and sets sticky overflow.
// UART_RX_FIFO_STATS_EN builds saturating err_cnt/drop_cnt counters, otherwise tied to zero.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rvld,
  input  logic [7:0]               rdata,
  input  logic                     uart_err,
  output logic                     m_valid,
  output logic [7:0]               m_data,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [CNT_WIDTH-1:0]     err_cnt,
  output logic [CNT_WIDTH-1:0]     drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;
  logic          full, rd_en, wr_en, drop;

  always_comb begin
    full     = (level_q == FULL_LVL);
    rd_en    = (level_q != '0) && m_ready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en    = rvld && (!full || rd_en);
    drop     = rvld && full && !rd_en;
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (wr_en && !rd_en)      level_d = level_q + LW'(1);
    else if (!wr_en && rd_en) level_d = level_q - LW'(1);
    almost_full_d = (level_d >= AF_LVL);
    overflow_d    = drop || (overflow_q && !overflow_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage needs no reset: the level counter decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rdata;
  end

  assign m_valid     = (level_q != '0);
  assign m_data      = m_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign level       = level_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;

`ifdef UART_RX_FIFO_STATS_EN
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (uart_err && (err_cnt_q != '1)) err_cnt_d  = err_cnt_q + CNT_WIDTH'(1);
    if (drop && (drop_cnt_q != '1))    drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  logic unused_uart_err;
  assign unused_uart_err = uart_err;
  assign err_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset, single byte, fill/drain, overflow, full read+write,
// randomized backpressure against a queue model, error counting and mid-stream reset.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, rvld, uart_err, m_ready, overflow_clr;
  logic [7:0] rdata;
  logic       m_valid, almost_full, overflow;
  logic [7:0] m_data;
  logic [4:0] level;
  logic [7:0] err_cnt, drop_cnt;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         sent, rcvd;
  logic [7:0] q[$];
  logic [7:0] hold_dat;
  logic       stall, rd;

  uart_rx_fifo #(.DEPTH(16), .AF_THRESH(12), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rvld(rvld), .rdata(rdata), .uart_err(uart_err),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .level(level),
    .almost_full(almost_full), .overflow(overflow), .overflow_clr(overflow_clr),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rvld = 1'b0; rdata = 8'h00; uart_err = 1'b0;
    m_ready = 1'b0; overflow_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_level", level, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 8'h00);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    // Single byte with the consumer ready
    rvld = 1'b1; rdata = 8'hA5; m_ready = 1'b1;
    step();
    rvld = 1'b0;
    chk("t1_valid", m_valid, 1);
    chk("t1_data", m_data, 8'hA5);
    chk("t1_level", level, 1);
    step();
    chk("t1_level_after", level, 0);
    chk("t1_valid_after", m_valid, 0);
    step();
    chk("t1_empty_read_level", level, 0);

    // Fill with 0x00..0x0F under full backpressure
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rvld = 1'b1; rdata = 8'(i);
      step();
      chk("t2_level", level, i + 1);
      chk("t2_af", almost_full, (i + 1 >= 12) ? 1 : 0);
    end
    rvld = 1'b0;
    chk("t2_ovf", overflow, 0);
    chk("t2_head", m_data, 8'h00);

    // Drop on full, then clear the sticky flag
    rvld = 1'b1; rdata = 8'hFF;
    step();
    rvld = 1'b0;
    chk("t3_ovf", overflow, 1);
    chk("t3_level", level, 16);
    chk("t3_drop_cnt", drop_cnt, STATS);
    chk("t3_head", m_data, 8'h00);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("t3_ovf_clr", overflow, 0);

    // Full with simultaneous read and write
    rvld = 1'b1; rdata = 8'h55; m_ready = 1'b1;
    step();
    rvld = 1'b0; m_ready = 1'b0;
    chk("t4_level", level, 16);
    chk("t4_ovf", overflow, 0);
    chk("t4_drop_cnt", drop_cnt, STATS);
    chk("t4_head", m_data, 8'h01);
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t4_drain_valid", m_valid, 1);
      chk("t4_drain_data", m_data, (k < 15) ? k + 1 : 8'h55);
      step();
    end
    m_ready = 1'b0;
    chk("t4_empty_valid", m_valid, 0);
    chk("t4_empty_level", level, 0);
    chk("t4_empty_af", almost_full, 0);

    // Random backpressure over 200 bytes against a queue model
    sent = 0; rcvd = 0; stall = 1'b0; hold_dat = 8'h00;
    for (int cyc = 0; cyc < 4000 && rcvd < 200; cyc++) begin
      chk("t5_valid", m_valid, (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) chk("t5_data", m_data, q[0]);
      if (stall) chk("t5_hold", m_data, hold_dat);
      chk("t5_level", level, q.size());
      m_ready  = 1'($urandom_range(0, 1));
      rd       = (q.size() > 0) && m_ready;
      rvld     = (sent < 200) && (q.size() < 16 || rd) && ($urandom_range(0, 1) == 1);
      rdata    = 8'(sent * 37 + 11);
      stall    = (q.size() > 0) && !m_ready;
      hold_dat = m_data;
      if (rd) begin
        void'(q.pop_front());
        rcvd++;
      end
      if (rvld) begin
        q.push_back(rdata);
        sent++;
      end
      step();
    end
    rvld = 1'b0; m_ready = 1'b0;
    chk("t5_received", rcvd, 200);
    chk("t5_ovf", overflow, 0);

    // Error pulses leave the FIFO alone, then a mid-stream reset
    rvld = 1'b1; rdata = 8'hAA; step();
    rdata = 8'hBB; step();
    rvld = 1'b0;
    for (int e = 0; e < 3; e++) begin
      uart_err = 1'b1; step();
      uart_err = 1'b0; step();
    end
    chk("t6_err_cnt", err_cnt, 3 * STATS);
    chk("t6_level", level, 2);
    chk("t6_head", m_data, 8'hAA);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_level", level, 0);
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_data", m_data, 8'h00);
    chk("t6_rst_err_cnt", err_cnt, 0);
    chk("t6_rst_drop_cnt", drop_cnt, 0);
    chk("t6_rst_ovf", overflow, 0);
    step();
    chk("t6_post_rst_valid", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
